// File: rtl/tick_pkg.sv
// Shared types and default divisors for the multi-channel tick generator.
package tick_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int NUM_CHAN  = 3;

  typedef logic [DIV_WIDTH-1:0] div_t;

  typedef struct packed {
    div_t div;
    logic mode;
    logic restart;
  } tick_cfg_t;

  // Reference clock and the slow rates derived from it.
  localparam int CLK_FREQ  = 100_000_000;
  localparam int SLOW_FREQ = 10_000_000;
  localparam int RTC_FREQ  = 1_000_000;
  localparam int BAUDRATE  = 115_200;

  localparam div_t DIV_PER  = div_t'(CLK_FREQ / SLOW_FREQ);
  localparam div_t DIV_RTC  = div_t'(CLK_FREQ / RTC_FREQ);
  localparam div_t DIV_BAUD = div_t'(CLK_FREQ / BAUDRATE);

  // Index 0 = peripheral, 1 = rtc, 2 = baud.
  localparam logic [NUM_CHAN-1:0][DIV_WIDTH-1:0] DIV_INIT_DEF = {DIV_BAUD, DIV_RTC, DIV_PER};

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/pending divisor, mode, tick and wave outputs.
module tick_channel
  import tick_pkg::*;
#(
  parameter div_t DIV_RESET = div_t'(1)
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      enable,
  input  logic      sync,
  input  logic      cfg_wr,
  input  tick_cfg_t cfg,
  output logic      tick,
  output logic      wave
);

  div_t cnt;
  div_t active_div;
  div_t pend_div;
  logic pend_vld;
  logic mode;
  div_t d_eff;
  logic at_wrap;
  logic mode_next;

  // Divisor 0 behaves as 1; wrap is the last count of an enabled period.
  always_comb begin
    d_eff     = (active_div == '0) ? div_t'(1) : active_div;
    at_wrap   = enable && (cnt == d_eff - div_t'(1));
    mode_next = cfg_wr ? cfg.mode : mode;
  end

  // Counter, divisor hand-over and output pulse generation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      active_div <= DIV_RESET;
      pend_div   <= '0;
      pend_vld   <= 1'b0;
      mode       <= 1'b0;
      tick       <= 1'b0;
      wave       <= 1'b0;
    end else begin
      mode <= mode_next;
      if (cfg_wr && cfg.restart) begin
        active_div <= cfg.div;
        cnt        <= '0;
        pend_vld   <= 1'b0;
        tick       <= 1'b0;
        wave       <= 1'b0;
      end else begin
        if (sync) begin
          cnt  <= '0;
          tick <= 1'b0;
        end else if (at_wrap) begin
          cnt  <= '0;
          tick <= 1'b1;
          if (mode) wave <= ~wave;
          if (pend_vld) begin
            active_div <= pend_div;
            pend_vld   <= 1'b0;
          end
        end else if (enable) begin
          cnt  <= cnt + div_t'(1);
          tick <= 1'b0;
        end else begin
          tick <= 1'b0;
        end
        // A deferred write lands after any hand-over above, so it stays pending.
        if (cfg_wr) begin
          pend_div <= cfg.div;
          pend_vld <= 1'b1;
        end
      end
      if (!mode_next) wave <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_divider.sv
// Multi-channel programmable tick generator: config decode, sync fan-out, channel array.
module tick_divider
  import tick_pkg::*;
#(
  parameter int CHANNELS = NUM_CHAN,
  parameter logic [CHANNELS-1:0][DIV_WIDTH-1:0] DIV_INIT = DIV_INIT_DEF,
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_mode,
  input  logic                 cfg_restart,
  output logic                 cfg_ready,
  input  logic [CHANNELS-1:0]  enable,
  input  logic                 sync,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  wave
);

  tick_cfg_t           cfg_bus;
  logic [CHANNELS-1:0] chan_wr;

  // Ready comes up one edge after reset release and stays up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cfg_ready <= 1'b0;
    else       cfg_ready <= 1'b1;
  end

  // Address decode; a channel index past the last channel selects nothing.
  always_comb begin
    cfg_bus = '{div: cfg_div, mode: cfg_mode, restart: cfg_restart};
    chan_wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chan_wr[i] = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(i));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    tick_channel #(
      .DIV_RESET (div_t'(DIV_INIT[i]))
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .enable (enable[i]),
      .sync   (sync),
      .cfg_wr (chan_wr[i]),
      .cfg    (cfg_bus),
      .tick   (tick[i]),
      .wave   (wave[i])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Randomised and directed bench for tick_divider with a queue-based scoreboard.
module tb_tick_divider;

  localparam int CH = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [1:0]  cfg_chan;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic        cfg_restart;
  logic        cfg_ready;
  logic [2:0]  enable;
  logic        sync;
  logic [2:0]  tick;
  logic [2:0]  wave;

  tick_divider dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_chan    (cfg_chan),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .cfg_restart (cfg_restart),
    .cfg_ready   (cfg_ready),
    .enable      (enable),
    .sync        (sync),
    .tick        (tick),
    .wave        (wave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] tick;
    logic [2:0] wave;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: each channel tracks how many enabled cycles of the
  // current period have elapsed; a period ends when that reaches d.
  int init_div[CH] = '{10, 100, 868};
  int m_active[CH];
  int m_pend[CH];
  bit m_pend_v[CH];
  bit m_mode[CH];
  int m_elapsed[CH];
  bit m_tick[CH];
  bit m_wave[CH];
  bit m_ready;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   wr;
    int   d;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_active[c] = init_div[c]; m_pend_v[c] = 0; m_mode[c] = 0;
        m_elapsed[c] = 0; m_tick[c] = 0; m_wave[c] = 0;
      end
      m_ready = 0;
    end else begin
      wr = cfg_valid && m_ready && (int'(cfg_chan) < CH);
      for (int c = 0; c < CH; c++) begin
        bit w;
        w = wr && (int'(cfg_chan) == c);
        d = (m_active[c] == 0) ? 1 : m_active[c];
        m_tick[c] = 0;
        if (w && cfg_restart) begin
          m_active[c] = int'(cfg_div); m_elapsed[c] = 0; m_pend_v[c] = 0; m_wave[c] = 0;
        end else begin
          if (sync) begin
            m_elapsed[c] = 0;
          end else if (enable[c]) begin
            m_elapsed[c]++;
            if (m_elapsed[c] == d) begin
              m_elapsed[c] = 0;
              m_tick[c] = 1;
              if (m_mode[c]) m_wave[c] = !m_wave[c];
              if (m_pend_v[c]) begin m_active[c] = m_pend[c]; m_pend_v[c] = 0; end
            end
          end
          if (w) begin m_pend[c] = int'(cfg_div); m_pend_v[c] = 1; end
        end
        if (w) m_mode[c] = cfg_mode;
        if (!m_mode[c]) m_wave[c] = 0;
      end
      m_ready = 1;
    end
    for (int c = 0; c < CH; c++) begin
      e.tick[c] = m_tick[c];
      e.wave[c] = m_wave[c];
    end
    e.ready = m_ready;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every registered output against the scoreboard.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("tick", 32'(tick), 32'(e.tick));
      check("wave", 32'(wave), 32'(e.wave));
      check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
    end
  end

  task automatic cycle(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      #1;
    end
  endtask

  task automatic write(int chan, int div, bit mode, bit restart);
    cfg_valid = 1; cfg_chan = 2'(chan); cfg_div = 16'(div);
    cfg_mode = mode; cfg_restart = restart;
    cycle();
    cfg_valid = 0;
  endtask

  initial begin
    reset = 1; cfg_valid = 0; cfg_chan = 0; cfg_div = 0; cfg_mode = 0;
    cfg_restart = 0; enable = 3'b111; sync = 0;
    cycle(3);
    reset = 0;

    // Defaults: periods 10 / 100 / 868.
    cycle(900);

    // Deferred divisor change mid-period on ch0.
    cycle(3);
    write(0, 4, 0, 0);
    cycle(30);

    // Immediate restart with wave mode on ch0.
    write(0, 5, 1, 1);
    cycle(40);

    // Divisor 0 and 1, then an enable gap of 7 cycles.
    write(1, 0, 1, 1);
    write(2, 1, 0, 1);
    cycle(10);
    enable = 3'b000;
    cycle(7);
    enable = 3'b111;
    cycle(12);

    // Phase alignment via sync, then sync landing on a wrap cycle.
    write(1, 7, 0, 1);
    cycle(3);
    write(2, 7, 0, 1);
    cycle(2);
    write(0, 7, 0, 1);
    cycle(4);
    sync = 1; cycle(); sync = 0;
    cycle(20);
    check("aligned_ticks", 32'(tick == 3'b000 || tick == 3'b111), 32'd1);
    sync = 1; cycle(); sync = 0;
    cycle(6);
    sync = 1; cycle(); sync = 0;
    check("sync_on_wrap_no_tick", 32'(tick), 32'd0);
    cycle(20);

    // Reset mid-count with a pending write.
    write(0, 3, 0, 0);
    cycle(2);
    @(negedge clock);
    #1;
    reset = 1;
    #1;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_wave", 32'(wave), 32'd0);
    check("reset_ready", 32'(cfg_ready), 32'd0);
    cycle(2);
    reset = 0;
    cycle(120);

    // Randomised traffic with small divisors, including out-of-range channels.
    for (int c = 0; c < CH; c++) write(c, $urandom_range(0, 12), 1'($urandom), 1);
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
      sync = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_chan = 2'($urandom_range(0, 3));
      cfg_div = 16'($urandom_range(0, 12));
      cfg_mode = 1'($urandom);
      cfg_restart = 1'($urandom);
      cycle();
    end
    cfg_valid = 0; sync = 0; enable = 3'b111;
    cycle(2);

    @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
